stage_1: RTL and testbench

STAGE_1 -- requirements
Module: stage_1

---
 rtl/stage_1.sv | 138 +++++++++++++
 tb/tb_stage_1.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_1.sv
// Instruction-fetch stage: drives the instruction memory and feeds a registered
// IF/ID pair to decode, with a one-entry skid buffer for stalls and branch redirect.
module stage_1 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        b_taken,
  input  logic [31:0] b_pc,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_inst,
  output logic [31:0] pc,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      r_state,       w_state_nxt;
  logic [31:0] r_fetch_pc,    w_fetch_pc_nxt;
  logic [31:0] r_buf_inst,    w_buf_inst_nxt;
  logic [31:0] r_buf_pc,      w_buf_pc_nxt;
  logic [31:0] r_redirect_pc, w_redirect_pc_nxt;
  logic [31:0] r_inst,        w_inst_nxt;
  logic [31:0] r_pc,          w_pc_nxt;
  logic        r_valid,       w_valid_nxt;
  logic        w_redirect;

  // A stalled decode stage cannot take a branch, so stall masks b_taken.
  assign w_redirect = b_taken && !stall;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_buf_inst_nxt    = r_buf_inst;
    w_buf_pc_nxt      = r_buf_pc;
    w_redirect_pc_nxt = r_redirect_pc;
    w_inst_nxt        = r_inst;
    w_pc_nxt          = r_pc;
    w_valid_nxt       = r_valid;

    if (w_redirect) begin
      w_inst_nxt  = NOP_INST;
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      FETCH: begin
        if (stall) begin
          if (imem_ready) begin
            w_buf_inst_nxt = imem_rdata;
            w_buf_pc_nxt   = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            w_state_nxt    = HOLD;
          end
        end else if (w_redirect) begin
          if (imem_ready) begin
            w_fetch_pc_nxt = b_pc;
          end else begin
            w_redirect_pc_nxt = b_pc;
            w_state_nxt       = DISCARD;
          end
        end else if (imem_ready) begin
          w_inst_nxt     = imem_rdata;
          w_pc_nxt       = r_fetch_pc;
          w_valid_nxt    = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end else begin
          w_inst_nxt  = NOP_INST;
          w_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (!stall) begin
          if (w_redirect) begin
            w_fetch_pc_nxt = b_pc;
          end else begin
            w_inst_nxt  = r_buf_inst;
            w_pc_nxt    = r_buf_pc;
            w_valid_nxt = 1'b1;
          end
          w_state_nxt = FETCH;
        end
      end
      DISCARD: begin
        // The stale request stays on the bus until memory answers it.
        if (!stall) begin
          w_inst_nxt  = NOP_INST;
          w_valid_nxt = 1'b0;
        end
        if (w_redirect) w_redirect_pc_nxt = b_pc;
        if (imem_ready) begin
          w_fetch_pc_nxt = w_redirect ? b_pc : r_redirect_pc;
          w_state_nxt    = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  // NOTE: the skid buffer is a pair of plain registers, so it is reset along with
  // everything else; this keeps a post-reset HOLD from ever exposing stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH;
      r_fetch_pc    <= RESET_PC;
      r_buf_inst    <= NOP_INST;
      r_buf_pc      <= 32'h0;
      r_redirect_pc <= 32'h0;
      r_inst        <= NOP_INST;
      r_pc          <= 32'h0;
      r_valid       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_buf_inst    <= w_buf_inst_nxt;
      r_buf_pc      <= w_buf_pc_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_inst        <= w_inst_nxt;
      r_pc          <= w_pc_nxt;
      r_valid       <= w_valid_nxt;
    end
  end

  assign imem_req    = !rst && (r_state != HOLD);
  assign imem_addr   = r_fetch_pc;
  assign if_id_inst  = r_inst;
  assign pc          = r_pc;
  assign if_id_valid = r_valid;

endmodule

// File: tb/tb_stage_1.sv
// Scenario bench for stage_1: a scoreboard of expected IF/ID loads plus inline
// checks on bubbles, fetch addresses and request handshakes.
module tb_stage_1;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, b_taken, imem_ready;
  logic [31:0] b_pc, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_inst, pc;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0001;
  endfunction

  // Memory returns an address-derived word for whatever address is on the bus.
  assign imem_rdata = word(imem_addr);

  stage_1 #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .b_taken(b_taken), .b_pc(b_pc),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .if_id_inst(if_id_inst), .pc(pc), .if_id_valid(if_id_valid)
  );

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc = a;
    e.inst = word(a);
    sb.push_back(e);
  endtask

  // One clock; any valid IF/ID load from an unstalled edge must match the scoreboard.
  task automatic tick();
    logic s;
    exp_t e;
    s = stall;
    @(posedge clk);
    #1;
    if (!s && if_id_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inst: got pc=%h inst=%h, required no valid instruction", pc, if_id_inst);
      end else begin
        e = sb.pop_front();
        if (pc !== e.pc || if_id_inst !== e.inst) begin
          errors++;
          $display("FAIL sb_inst: got pc=%h inst=%h, required pc=%h inst=%h", pc, if_id_inst, e.pc, e.inst);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_inst !== NOP || pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got req=%b valid=%b inst=%h pc=%h, required 0 0 %h 0", imem_req, if_id_valid, if_id_inst, pc, NOP);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_release: got req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(32'(i * 4));
      tick();
      checks++;
      if (if_id_valid !== 1'b1 || pc !== 32'(i * 4)) begin
        errors++;
        $display("FAIL stream_%0d: got valid=%b pc=%h, required 1 %h", i, if_id_valid, pc, 32'(i * 4));
      end
    end
    checks++;
    if (imem_addr !== 32'd16) begin
      errors++;
      $display("FAIL stream_addr: got %h, required 00000010", imem_addr);
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || pc !== 32'h0 || if_id_inst !== NOP) begin
      errors++;
      $display("FAIL async_reset: got req=%b valid=%b pc=%h inst=%h, required 0 0 0 %h", imem_req, if_id_valid, pc, if_id_inst, NOP);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL async_reset_release: got req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_wait();
    imem_ready = 1'b1;
    push(32'd0); tick();
    push(32'd4); tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (if_id_valid !== 1'b0 || if_id_inst !== NOP || pc !== 32'd4 || imem_addr !== 32'd8 || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL wait_bubble_%0d: got valid=%b inst=%h pc=%h addr=%h req=%b, required 0 %h 4 8 1",
                 i, if_id_valid, if_id_inst, pc, imem_addr, imem_req, NOP);
      end
    end
    imem_ready = 1'b1;
    push(32'd8);
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || pc !== 32'd8) begin
      errors++;
      $display("FAIL wait_resume: got valid=%b pc=%h, required 1 8", if_id_valid, pc);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // Middle stall cycle also carries a branch, which must be ignored.
      b_taken = (i == 1);
      b_pc = 32'h300;
      tick();
      checks++;
      if (if_id_valid !== 1'b1 || pc !== 32'd8 || if_id_inst !== word(32'd8) || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got valid=%b pc=%h inst=%h req=%b, required 1 8 %h 0",
                 i, if_id_valid, pc, if_id_inst, imem_req, word(32'd8));
      end
    end
    stall = 1'b0;
    b_taken = 1'b0;
    push(32'd12);
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || pc !== 32'd12 || imem_req !== 1'b1 || imem_addr !== 32'd16) begin
      errors++;
      $display("FAIL stall_release: got valid=%b pc=%h req=%b addr=%h, required 1 c 1 10", if_id_valid, pc, imem_req, imem_addr);
    end
  endtask

  task automatic test_branch();
    b_taken = 1'b1;
    b_pc = 32'h100;
    tick();
    b_taken = 1'b0;
    checks++;
    if (if_id_valid !== 1'b0 || if_id_inst !== NOP || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL branch_flush: got valid=%b inst=%h addr=%h, required 0 %h 100", if_id_valid, if_id_inst, imem_addr, NOP);
    end
    push(32'h100);
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || pc !== 32'h100) begin
      errors++;
      $display("FAIL branch_target: got valid=%b pc=%h, required 1 100", if_id_valid, pc);
    end
  endtask

  task automatic test_branch_pending();
    b_taken = 1'b1;
    b_pc = 32'd20;
    tick();
    imem_ready = 1'b0;
    b_pc = 32'h180;
    tick();
    for (int i = 0; i < 2; i++) begin
      // Second branch while discarding replaces the pending redirect target.
      b_taken = (i == 0);
      b_pc = 32'h200;
      tick();
      checks++;
      if (if_id_valid !== 1'b0 || imem_addr !== 32'd20 || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL discard_hold_%0d: got valid=%b addr=%h req=%b, required 0 14 1", i, if_id_valid, imem_addr, imem_req);
      end
    end
    imem_ready = 1'b1;
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL discard_drop: got valid=%b addr=%h, required 0 200", if_id_valid, imem_addr);
    end
    push(32'h200);
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || pc !== 32'h200) begin
      errors++;
      $display("FAIL discard_target: got valid=%b pc=%h, required 1 200", if_id_valid, pc);
    end
  endtask

  task automatic test_wrap();
    b_taken = 1'b1;
    b_pc = 32'hFFFF_FFFC;
    tick();
    b_taken = 1'b0;
    push(32'hFFFF_FFFC);
    tick();
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got %h, required 00000000", imem_addr);
    end
    push(32'h0);
    tick();
    checks++;
    if (pc !== 32'h0 || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pc: got pc=%h valid=%b, required 0 1", pc, if_id_valid);
    end
  endtask

  task automatic test_hold_branch();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    b_taken = 1'b1;
    b_pc = 32'h400;
    tick();
    b_taken = 1'b0;
    checks++;
    if (if_id_valid !== 1'b0 || imem_addr !== 32'h400 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL hold_branch: got valid=%b addr=%h req=%b, required 0 400 1", if_id_valid, imem_addr, imem_req);
    end
    push(32'h400);
    tick();
  endtask

  task automatic test_stall_fetch_branch();
    stall = 1'b1;
    b_taken = 1'b1;
    b_pc = 32'h500;
    imem_ready = 1'b0;
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || pc !== 32'h400 || imem_addr !== 32'h404 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_fetch_branch: got valid=%b pc=%h addr=%h req=%b, required 1 400 404 1",
               if_id_valid, pc, imem_addr, imem_req);
    end
    stall = 1'b0;
    b_taken = 1'b0;
    imem_ready = 1'b1;
    push(32'h404);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    b_taken = 1'b0;
    b_pc = 32'h0;
    imem_ready = 1'b0;
    test_reset();
    test_stream();
    test_async_reset();
    test_wait();
    test_stall();
    test_branch();
    test_branch_pending();
    test_wrap();
    test_hold_branch();
    test_stall_fetch_branch();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
